// File: rtl/raster_pkg.sv
// Shared constants and state encoding for the raster_scan point generator.
package raster_pkg;

    localparam int COORD_W = 11;
    localparam int PHASES  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD0,
        ST_LOAD1,
        ST_LOAD2,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/minmax3.sv
// Combinational unsigned minimum and maximum of three coordinates.
module minmax3
    import raster_pkg::*;
#(
    parameter int W = COORD_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic [W-1:0] ab_lo;
    logic [W-1:0] ab_hi;

    assign ab_lo = (a < b) ? a : b;
    assign ab_hi = (a < b) ? b : a;
    assign lo    = (c < ab_lo) ? c : ab_lo;
    assign hi    = (c > ab_hi) ? c : ab_hi;

endmodule

// File: rtl/raster_scan.sv
// Triangle bounding-box point generator feeding the edge-sign stage.
// Optional screen clipping is enabled by defining RASTER_CLIP_EN.
module raster_scan
    import raster_pkg::*;
#(
    parameter int W        = COORD_W,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int DRAIN    = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         start,
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    input  logic [W-1:0] cx,
    input  logic [W-1:0] cy,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic         ore,
    output logic         orst,
    output logic         busy,
    output logic         done
);

    localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t        state;
    logic [W-1:0]  ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
    logic [W-1:0]  xmin, xmax, ymin, ymax;
    logic [W-1:0]  px, py;
    logic [1:0]    phase;
    logic [CW-1:0] drain_cnt;

    logic [W-1:0]  xs_lo, xs_hi, ys_lo, ys_hi;
    logic [W-1:0]  xmax_c, ymax_c;
    logic          box_empty;

    minmax3 #(.W(W)) u_mm_x (.a(ax_r), .b(bx_r), .c(cx_r), .lo(xs_lo), .hi(xs_hi));
    minmax3 #(.W(W)) u_mm_y (.a(ay_r), .b(by_r), .c(cy_r), .lo(ys_lo), .hi(ys_hi));

`ifdef RASTER_CLIP_EN
    localparam logic [W-1:0] X_LAST = W'(SCREEN_W - 1);
    localparam logic [W-1:0] Y_LAST = W'(SCREEN_H - 1);

    assign xmax_c    = (xs_hi > X_LAST) ? X_LAST : xs_hi;
    assign ymax_c    = (ys_hi > Y_LAST) ? Y_LAST : ys_hi;
    assign box_empty = (xs_lo > X_LAST) || (ys_lo > Y_LAST);
`else
    assign xmax_c    = xs_hi;
    assign ymax_c    = ys_hi;
    assign box_empty = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (r) begin
            state     <= ST_IDLE;
            {ax_r, ay_r, bx_r, by_r, cx_r, cy_r} <= '0;
            {xmin, xmax, ymin, ymax} <= '0;
            px        <= '0;
            py        <= '0;
            phase     <= '0;
            drain_cnt <= '0;
            o1        <= '0;
            o2        <= '0;
            ore       <= 1'b0;
            orst      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle so only the states below raise them.
            ore  <= 1'b0;
            orst <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ax_r  <= ax;
                        ay_r  <= ay;
                        bx_r  <= bx;
                        by_r  <= by;
                        cx_r  <= cx;
                        cy_r  <= cy;
                        busy  <= 1'b1;
                        orst  <= 1'b1;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    xmin <= xs_lo;
                    xmax <= xmax_c;
                    ymin <= ys_lo;
                    ymax <= ymax_c;
                    if (box_empty) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        o1    <= ax_r;
                        o2    <= ay_r;
                        state <= ST_LOAD0;
                    end
                end
                ST_LOAD0: begin
                    o1    <= bx_r;
                    o2    <= by_r;
                    state <= ST_LOAD1;
                end
                ST_LOAD1: begin
                    o1    <= cx_r;
                    o2    <= cy_r;
                    state <= ST_LOAD2;
                end
                ST_LOAD2: begin
                    px    <= xmin;
                    py    <= ymin;
                    o1    <= xmin;
                    o2    <= ymin;
                    phase <= '0;
                    ore   <= 1'b1;
                    state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (phase != 2'(PHASES - 1)) begin
                        phase <= phase + 2'd1;
                    end else begin
                        phase <= '0;
                        if (px == xmax && py == ymax) begin
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end else begin
                            ore <= 1'b1;
                            if (px == xmax) begin
                                px <= xmin;
                                py <= py + 1'b1;
                                o1 <= xmin;
                                o2 <= py + 1'b1;
                            end else begin
                                px <= px + 1'b1;
                                o1 <= px + 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == CW'(DRAIN - 1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_scan.sv
// Scoreboard bench for raster_scan: expected events are queued by the driver and consumed by a monitor.
module tb_raster_scan;

    localparam int W        = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int DRAIN    = 4;

    typedef struct {
        int x;
        int y;
        int cyc;
    } ev_t;

    logic         clk = 1'b0;
    logic         r;
    logic         start;
    logic [W-1:0] ax, ay, bx, by, cx, cy;
    logic [W-1:0] o1, o2;
    logic         ore, orst, busy, done;

    raster_scan #(
        .W(W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .DRAIN(DRAIN)
    ) dut (
        .clk(clk), .r(r), .start(start),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .o1(o1), .o2(o2), .ore(ore), .orst(orst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    ev_t out_q[$];
    ev_t pt_q[$];
    int  done_q[$];
    int  rst_q[$];
    int  busy_lo = 1;
    int  busy_hi = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Reference model: derive every expected observation of a job accepted at edge k+1.
    task automatic expect_job(input int k, input int v[6]);
        int e = k + 1;
        int x0 = min3(v[0], v[2], v[4]);
        int x1 = max3(v[0], v[2], v[4]);
        int y0 = min3(v[1], v[3], v[5]);
        int y1 = max3(v[1], v[3], v[5]);
        bit empty = 1'b0;
        int n, total, i;
`ifdef RASTER_CLIP_EN
        if (x0 >= SCREEN_W || y0 >= SCREEN_H) empty = 1'b1;
        if (x1 > SCREEN_W - 1) x1 = SCREEN_W - 1;
        if (y1 > SCREEN_H - 1) y1 = SCREEN_H - 1;
`endif
        rst_q.push_back(e);
        if (empty) begin
            total = 2;
        end else begin
            n     = (x1 - x0 + 1) * (y1 - y0 + 1);
            total = 1 + 3 + 3 * n + DRAIN + 1;
            for (int j = 0; j < 3; j++) out_q.push_back(ev_t'{v[2*j], v[2*j+1], e + 1 + j});
            i = 0;
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x++) begin
                    pt_q.push_back(ev_t'{x, y, e + 4 + 3 * i});
                    for (int p = 0; p < 3; p++) out_q.push_back(ev_t'{x, y, e + 4 + 3 * i + p});
                    i++;
                end
            end
            for (int d = 0; d < DRAIN; d++) out_q.push_back(ev_t'{x1, y1, e + 4 + 3 * n + d});
        end
        done_q.push_back(e + total - 1);
        busy_lo = e;
        busy_hi = e + total - 1;
    endtask

    // Monitor: samples 2 time units after each rising edge.
    ev_t mev;
    int  mcyc;
    always @(posedge clk) begin
        #2;
        check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
            mev = out_q.pop_front();
            check("point_hold_missed", cyc, mev.cyc);
        end
        if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
            mev = out_q.pop_front();
            check("o1", o1, mev.x);
            check("o2", o2, mev.y);
        end
        while (pt_q.size() > 0 && pt_q[0].cyc < cyc) begin
            mev = pt_q.pop_front();
            check("ore_missing", cyc, mev.cyc);
        end
        if (ore) begin
            if (pt_q.size() == 0) check("ore_unexpected", ore, 0);
            else begin
                mev = pt_q.pop_front();
                check("ore_cycle", cyc, mev.cyc);
                check("ore_x", o1, mev.x);
                check("ore_y", o2, mev.y);
            end
        end
        if (done) begin
            if (done_q.size() == 0) check("done_unexpected", done, 0);
            else begin
                mcyc = done_q.pop_front();
                check("done_cycle", cyc, mcyc);
            end
        end
        if (orst) begin
            if (rst_q.size() == 0) check("orst_unexpected", orst, 0);
            else begin
                mcyc = rst_q.pop_front();
                check("orst_cycle", cyc, mcyc);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive_v(input int v[6]);
        ax = W'(v[0]); ay = W'(v[1]);
        bx = W'(v[2]); by = W'(v[3]);
        cx = W'(v[4]); cy = W'(v[5]);
    endtask

    task automatic drive_junk();
        ax = W'($urandom); ay = W'($urandom);
        bx = W'($urandom); by = W'($urandom);
        cx = W'($urandom); cy = W'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_o1"}, o1, 0);
        check({tag, "_o2"}, o2, 0);
        check({tag, "_ore"}, ore, 0);
        check({tag, "_orst"}, orst, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Called at a falling edge. With pre_hold, start is first raised during the DONE cycle of the previous job.
    task automatic launch(input int v[6], input bit pre_hold);
        if (pre_hold) begin
            start = 1'b1;
            drive_v(v);
            @(negedge clk);
        end
        start = 1'b1;
        drive_v(v);
        expect_job(cyc, v);
        @(negedge clk);
        start = 1'b0;
        drive_junk();
    endtask

    task automatic finish_job();
        wait_until(busy_hi + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[6];
        int base_x, base_y;
        bit hold;

        r     = 1'b1;
        start = 1'b0;
        drive_junk();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            start = ~start;
            drive_junk();
            @(negedge clk);
            check_all_zero("in_reset");
        end
        r     = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all_zero("idle");
        end

        v = '{2, 3, 4, 3, 2, 5};
        launch(v, 1'b0);
        finish_job();

        v = '{7, 7, 7, 7, 7, 7};
        launch(v, 1'b0);
        finish_job();

        v = '{10, 20, 11, 20, 10, 21};
        launch(v, 1'b0);
        wait_until(busy_lo + 6);
        start = 1'b1;
        v = '{0, 0, 100, 100, 0, 0};
        drive_v(v);
        @(negedge clk);
        start = 1'b0;
        finish_job();

        v = '{0, 0, 5, 0, 0, 5};
        launch(v, 1'b0);
        wait_until(busy_lo + 20);
        r = 1'b1;
        out_q.delete();
        pt_q.delete();
        done_q.delete();
        rst_q.delete();
        busy_hi = cyc;
        @(negedge clk);
        check_all_zero("abort");
        r = 1'b0;
        @(negedge clk);
        v = '{1, 1, 2, 1, 1, 2};
        launch(v, 1'b0);
        finish_job();

`ifdef RASTER_CLIP_EN
        v = '{630, 470, 700, 470, 630, 500};
        launch(v, 1'b0);
        finish_job();
        v = '{700, 10, 800, 20, 900, 30};
        launch(v, 1'b0);
        finish_job();
`endif

        for (int j = 0; j < 20; j++) begin
            base_x = $urandom_range(2040, 0);
            base_y = $urandom_range(2040, 0);
            for (int q = 0; q < 3; q++) begin
                v[2*q]   = base_x + $urandom_range(3, 0);
                v[2*q+1] = base_y + $urandom_range(3, 0);
            end
            hold = (j > 0) && ($urandom_range(1, 0) == 1);
            if (hold) wait_until(busy_hi);
            else wait_until(busy_hi + 1 + $urandom_range(3, 0));
            launch(v, hold);
        end
        finish_job();

        wait_until(busy_hi + 4);
        check("pending_outputs", out_q.size(), 0);
        check("pending_points", pt_q.size(), 0);
        check("pending_done", done_q.size(), 0);
        check("pending_orst", rst_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
